i2c_interface_arbiter: RTL and testbench

- Shares one controller-facing I2C interface bundle among NUM_REQ daughter-side requesters.
- Requesters hold a request line. The arbiter grants one requester at a time, round-robin, and locks the grant for one full transaction:
  - the command packet (write phase, ended by the packet strobe), then
  - the response drain (read phase).
- Sits between the daughter modules and the I2C controller's FIFO pair. Controller-side signals are the per-bit equivalents of the interface bundle.

---
 rtl/i2c_interface_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_interface_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_interface_arbiter.sv
// Round-robin arbiter sharing one controller-side I2C FIFO pair among NUM_REQ requesters.
// A grant is held for a whole transaction: command packet out, then response drain back.
module i2c_interface_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RSP_IDLE    = 16,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   grant_o,
  input  logic [8*NUM_REQ-1:0] req_dat_i,
  input  logic [NUM_REQ-1:0]   req_wr_i,
  output logic [NUM_REQ-1:0]   req_full_o,
  input  logic [NUM_REQ-1:0]   req_packet_i,
  output logic [7:0]           req_dat_o,
  input  logic [NUM_REQ-1:0]   req_rd_i,
  output logic [NUM_REQ-1:0]   req_empty_o,
  output logic [7:0]           dat_o,
  output logic                 wr_o,
  input  logic                 full_i,
  output logic                 packet_o,
  input  logic [7:0]           dat_i,
  output logic                 rd_o,
  input  logic                 empty_i,
  output logic                 timeout_o
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int IW = $clog2(RSP_IDLE);
  localparam int TW = $clog2(RSP_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               timeout_q, timeout_d;
  logic               got_data_q, got_data_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;

  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic [OW-1:0]      cand;
  logic               fwd_w;
  logic               fwd_r;
  logic [NUM_REQ-1:0] own_sel;
  logic [7:0]         dat_arr [NUM_REQ];

  // Search starts just after the previous owner, so a releasing requester goes to the back.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_q) + i) % NUM_REQ);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign fwd_w = ~rst_i & (state_q == ST_WRITE);
  assign fwd_r = ~rst_i & (state_q == ST_READ);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign own_sel[gi]     = (owner_q == OW'(gi));
      assign dat_arr[gi]     = req_dat_i[8*gi +: 8];
      assign req_full_o[gi]  = (fwd_w & own_sel[gi]) ? full_i  : 1'b1;
      assign req_empty_o[gi] = (fwd_r & own_sel[gi]) ? empty_i : 1'b1;
    end
  endgenerate

  assign dat_o     = fwd_w ? dat_arr[owner_q] : 8'h00;
  assign wr_o      = fwd_w & req_wr_i[owner_q];
  assign packet_o  = fwd_w & req_packet_i[owner_q];
  assign rd_o      = fwd_r & req_rd_i[owner_q] & ~empty_i;
  assign req_dat_o = dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    got_data_d = got_data_q;
    idle_cnt_d = idle_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          owner_d           = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d           = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (req_packet_i[owner_q]) begin
          state_d    = ST_READ;
          got_data_d = 1'b0;
          idle_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (!empty_i) begin
          got_data_d = 1'b1;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (!got_data_q && to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // Quiet gap after a response ends normally; no response at all is abandoned.
        if (got_data_q && empty_i && idle_cnt_q == IW'(RSP_IDLE - 1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else if (!got_data_q && to_cnt_q == TW'(RSP_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= OW'(NUM_REQ - 1);
      grant_q    <= '0;
      timeout_q  <= 1'b0;
      got_data_q <= 1'b0;
      idle_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      got_data_q <= got_data_d;
      idle_cnt_q <= idle_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_i2c_interface_arbiter.sv
// Bench for i2c_interface_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i2c_interface_arbiter;
  localparam int N  = 4;
  localparam int RI = 16;
  localparam int RT = 1024;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N-1:0]   grant_o;
  logic [8*N-1:0] req_dat_i;
  logic [N-1:0]   req_wr_i;
  logic [N-1:0]   req_full_o;
  logic [N-1:0]   req_packet_i;
  logic [7:0]     req_dat_o;
  logic [N-1:0]   req_rd_i;
  logic [N-1:0]   req_empty_o;
  logic [7:0]     dat_o;
  logic           wr_o;
  logic           full_i;
  logic           packet_o;
  logic [7:0]     dat_i;
  logic           rd_o;
  logic           empty_i;
  logic           timeout_o;

  i2c_interface_arbiter #(.NUM_REQ(N), .RSP_IDLE(RI), .RSP_TIMEOUT(RT)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .grant_o(grant_o),
    .req_dat_i(req_dat_i), .req_wr_i(req_wr_i), .req_full_o(req_full_o),
    .req_packet_i(req_packet_i), .req_dat_o(req_dat_o), .req_rd_i(req_rd_i),
    .req_empty_o(req_empty_o), .dat_o(dat_o), .wr_o(wr_o), .full_i(full_i),
    .packet_o(packet_o), .dat_i(dat_i), .rd_o(rd_o), .empty_i(empty_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase 0=idle 1=command 2=response; response end decided from timestamps.
  int       m_phase  = 0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_last  = 2'(N - 1);
  int       m_rstart = 0;
  int       m_ldata  = -1;
  bit       m_to     = 1'b0;
  logic [N-1:0] e_grant, e_full, e_empty;
  bit       ew, er, e_wr, e_pkt, e_rd, found;
  logic [1:0] idx2;

  always @(negedge clk) begin
    if (chk_en) begin
      ew = !rst_i && m_phase == 1;
      er = !rst_i && m_phase == 2;
      e_grant = '0;
      if (m_phase != 0) e_grant[m_owner] = 1'b1;
      e_full  = '1;
      e_empty = '1;
      if (ew) e_full[m_owner] = full_i;
      if (er) e_empty[m_owner] = empty_i;
      e_wr  = ew && req_wr_i[m_owner];
      e_pkt = ew && req_packet_i[m_owner];
      e_rd  = er && req_rd_i[m_owner] && !empty_i;
      check("grant_o", 32'(grant_o), 32'(e_grant));
      check("timeout_o", 32'(timeout_o), 32'(m_to));
      check("wr_o", 32'(wr_o), 32'(e_wr));
      check("packet_o", 32'(packet_o), 32'(e_pkt));
      check("rd_o", 32'(rd_o), 32'(e_rd));
      check("req_full_o", 32'(req_full_o), 32'(e_full));
      check("req_empty_o", 32'(req_empty_o), 32'(e_empty));
      check("req_dat_o", 32'(req_dat_o), 32'(dat_i));
      if (e_wr) check("dat_o", 32'(dat_o), 32'(8'(req_dat_i >> (8 * int'(m_owner)))));
    end
    if (rst_i) begin
      m_phase = 0;
      m_last  = 2'(N - 1);
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx2 = 2'((int'(m_last) + k) % N);
            if (!found && req_i[idx2]) begin
              found   = 1'b1;
              m_owner = idx2;
              m_phase = 1;
            end
          end
        end
        1: if (req_packet_i[m_owner]) begin
          m_phase  = 2;
          m_rstart = cyc + 1;
          m_ldata  = -1;
        end
        default: begin
          if (m_ldata >= 0 && empty_i && cyc - m_ldata == RI) begin
            m_phase = 0;
            m_last  = m_owner;
          end else if (m_ldata < 0 && cyc - m_rstart == RT - 1) begin
            m_phase = 0;
            m_last  = m_owner;
            m_to    = 1'b1;
          end else if (!empty_i) begin
            m_ldata = cyc;
          end
        end
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int idx, output int waited);
    idx = -1;
    waited = 0;
    while (idx < 0 && waited < 64) begin
      step();
      waited++;
      for (int b = 0; b < N; b++) if (((grant_o >> b) & 1) != 0) idx = b;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: got no grant, expected a grant within 64 cycles");
    end
  endtask

  // Owner o sends two bytes and a packet; controller returns nd bytes, then stays empty.
  task automatic do_txn(input int o, input int nd);
    int n;
    full_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      req_dat_i = $urandom;
      req_wr_i  = 4'(1 << o);
      step();
    end
    req_wr_i     = '0;
    req_packet_i = 4'(1 << o);
    step();
    req_packet_i = '0;
    for (int d = 0; d < nd; d++) begin
      empty_i  = 1'b0;
      dat_i    = 8'($urandom);
      req_rd_i = 4'(1 << o);
      step();
    end
    empty_i  = 1'b1;
    req_rd_i = '0;
    n = 0;
    while (grant_o != 0 && n < 1100) begin
      step();
      n++;
    end
    check("release_delay", n, (nd > 0) ? RI : RT);
    check("timeout_at_release", 32'(timeout_o), (nd == 0) ? 32'd1 : 32'd0);
  endtask

  int idx, waited;
  int order [5] = '{0, 1, 2, 3, 0};
  int burst, gap;

  initial begin
    rst_i = 1'b1; req_i = '0; req_dat_i = '0; req_wr_i = '0; req_packet_i = '0;
    req_rd_i = '0; full_i = 1'b0; dat_i = '0; empty_i = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_full", 32'(req_full_o), 32'hF);
    check("rst_empty", 32'(req_empty_o), 32'hF);
    check("rst_timeout", 32'(timeout_o), 32'h0);

    // Basic transaction for requester 0
    rst_i = 1'b0; req_i = 4'b0001;
    step(); #1;
    check("first_grant", 32'(grant_o), 32'h1);
    req_i = '0; req_wr_i = 4'b0010; req_packet_i = 4'b0010; full_i = 1'b0;
    #1;
    check("nonowner_wr", 32'(wr_o), 32'h0);
    check("nonowner_pkt", 32'(packet_o), 32'h0);
    check("nonowner_full", 32'(req_full_o), 32'hE);
    step();
    req_packet_i = '0; req_wr_i = 4'b0001; req_dat_i = 32'h0000_00A5;
    #1;
    check("wr_a5", 32'(wr_o), 32'h1);
    check("dat_a5", 32'(dat_o), 32'hA5);
    step();
    req_dat_i = 32'h0000_003C;
    #1;
    check("dat_3c", 32'(dat_o), 32'h3C);
    step();
    req_wr_i = '0; req_packet_i = 4'b0001;
    #1;
    check("packet", 32'(packet_o), 32'h1);
    step();
    req_packet_i = '0; req_wr_i = 4'b0001;
    #1;
    check("read_no_wr", 32'(wr_o), 32'h0);
    check("read_full", 32'(req_full_o), 32'hF);
    req_wr_i = '0;
    empty_i = 1'b0; dat_i = 8'h11; req_rd_i = 4'b0001;
    #1;
    check("rd_1", 32'(rd_o), 32'h1);
    check("rdat_1", 32'(req_dat_o), 32'h11);
    check("rempty_1", 32'(req_empty_o), 32'hE);
    step();
    dat_i = 8'h22;
    #1;
    check("rdat_2", 32'(req_dat_o), 32'h22);
    step();
    empty_i = 1'b1;
    #1;
    check("rd_empty", 32'(rd_o), 32'h0);
    waited = 0;
    while (grant_o != 0 && waited < 100) begin
      step();
      waited++;
    end
    req_rd_i = '0;
    check("idle_release", waited, RI);
    check("idle_no_timeout", 32'(timeout_o), 32'h0);

    // Round robin with everyone requesting, from reset
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0; req_i = 4'hF;
    for (int t = 0; t < 5; t++) begin
      wait_grant(idx, waited);
      check("rr_owner", idx, order[t]);
      check("rr_latency", waited, 1);
      if (idx >= 0) do_txn(idx, 1 + (t % 2));
    end

    // Abandoned response, then next requester
    req_i = 4'b0110;
    wait_grant(idx, waited);
    check("to_owner", idx, 1);
    if (idx >= 0) do_txn(idx, 0);
    step(); #1;
    check("timeout_pulse_len", 32'(timeout_o), 32'h0);
    check("grant_after_timeout", 32'(grant_o), 32'h4);

    // Reset in the middle of a command
    req_i = '0; req_dat_i = 32'h0077_0000; req_wr_i = 4'b0100;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; req_i = 4'hF;
    #1;
    check("mid_rst_grant", 32'(grant_o), 32'h0);
    check("mid_rst_wr", 32'(wr_o), 32'h0);
    check("mid_rst_full", 32'(req_full_o), 32'hF);
    check("mid_rst_empty", 32'(req_empty_o), 32'hF);
    step(); #1;
    check("post_rst_grant", 32'(grant_o), 32'h1);

    // Randomized traffic
    burst = 0; gap = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_i        = ($urandom_range(0, 599) == 0);
      req_i        = 4'($urandom);
      req_dat_i    = $urandom;
      req_wr_i     = 4'($urandom);
      req_packet_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_rd_i     = 4'($urandom);
      full_i       = 1'($urandom);
      dat_i        = 8'($urandom);
      if (burst > 0) begin
        empty_i = 1'b0;
        burst--;
      end else if (gap > 0) begin
        empty_i = 1'b1;
        gap--;
      end else begin
        empty_i = 1'b1;
        burst = $urandom_range(1, 3);
        gap = $urandom_range(0, 30);
      end
      step();
    end

    rst_i = 1'b1;
    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
